// File: rtl/sw_debounce8_if.sv
// Bundles the raw switch lines and enable toward the debouncer together with
// the clean request vector and edge pulses it hands to the priority encoder.
interface sw_debounce8_if;
    logic [7:0] sw_in;
    logic       en;
    logic [7:0] x_out;
    logic       chg;
    logic [7:0] rise;
    logic [7:0] fall;

    modport master (
        output sw_in, en,
        input  x_out, chg, rise, fall
    );

    modport slave (
        input  sw_in, en,
        output x_out, chg, rise, fall
    );
endinterface

// File: rtl/sw_debounce8.sv
// Eight-channel switch conditioner: two-flop synchroniser, independent per-bit
// stability counters, and registered rise/fall/change pulses on the clean vector.
module sw_debounce8 #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input logic           clk,
    input logic           rst,
    sw_debounce8_if.slave bus
);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       s1_q, s2_q;
    logic [7:0]       x_q, x_d;
    logic [7:0]       rise_q, rise_d;
    logic [7:0]       fall_q, fall_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // A bit flips only after its synchronised value has disagreed with the
    // output for STABLE_CYCLES consecutive enabled edges; any agreement or a
    // low enable clears its counter.
    always_comb begin
        x_d = x_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (bus.en && (s2_q[i] != x_q[i])) begin
                if (cnt_q[i] == CntLast) begin
                    x_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = x_d & ~x_q;
        fall_d = ~x_d & x_q;
        chg_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= bus.sw_in;
            s2_q   <= s1_q;
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.x_out = x_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.chg   = chg_q;
endmodule

// File: tb/tb_sw_debounce8.sv
// Cycle-by-cycle check of sw_debounce8 with STABLE_CYCLES=4: each driven cycle
// queues the outputs expected after its clock edge, compared just after that edge.
module tb_sw_debounce8;
    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] sw;
        int         n;
        logic [7:0] x;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     fails  = 0;
    int     step   = 0;
    exp_t   expQ[$];
    vec_t   vecs[$];

    sw_debounce8_if bus ();

    sw_debounce8 #(
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(input logic r, input logic e, input logic [7:0] s, input int n,
                                 input logic [7:0] x, input logic [7:0] ri, input logic [7:0] fa,
                                 input logic c);
        vec_t v;
        v.rst = r; v.en = e; v.sw = s; v.n = n;
        v.x = x; v.rise = ri; v.fall = fa; v.chg = c;
        return v;
    endfunction

    // Drives one cycle of inputs and queues the outputs expected after the next edge
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst       = v.rst;
        bus.en    = v.en;
        bus.sw_in = v.sw;
        e.x = v.x; e.rise = v.rise; e.fall = v.fall; e.chg = v.chg;
        expQ.push_back(e);
    endtask

    task automatic compare8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", step);
            return;
        end
        e = expQ.pop_front();
        compare8("x_out", bus.x_out, e.x);
        compare8("rise", bus.rise, e.rise);
        compare8("fall", bus.fall, e.fall);
        compare8("chg", {7'd0, bus.chg}, {7'd0, e.chg});
        step++;
    endtask

    task automatic runRow(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            applyStimulus(v);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic runTable();
        foreach (vecs[j]) runRow(vecs[j]);
        vecs.delete();
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.sw_in = 8'h00;

        // Reset with all inputs high, then release: flip lands on the 6th edge
        vecs.push_back(row(1, 1, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'hFF, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 1));
        vecs.push_back(row(0, 1, 8'hFF, 2, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h0F, 5, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h0F, 1, 8'h0F, 8'h00, 8'hF0, 1));
        vecs.push_back(row(0, 1, 8'h0F, 2, 8'h0F, 8'h00, 8'h00, 0));
        // Simultaneous channels
        vecs.push_back(row(0, 1, 8'hF0, 5, 8'h0F, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'hF0, 1, 8'hF0, 8'hF0, 8'h0F, 1));
        vecs.push_back(row(0, 1, 8'hF0, 2, 8'hF0, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 5, 8'hF0, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 1, 8'h00, 8'h00, 8'hF0, 1));
        vecs.push_back(row(0, 1, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0));
        // 3-cycle glitch: counter reaches its last value then the input reverts
        vecs.push_back(row(0, 1, 8'h08, 3, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 4, 8'h00, 8'h00, 8'h00, 0));
        // 4-cycle pulse is long enough to flip, then falls back after its own delay
        vecs.push_back(row(0, 1, 8'h08, 4, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 1, 8'h08, 8'h08, 8'h00, 1));
        vecs.push_back(row(0, 1, 8'h00, 3, 8'h08, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 1, 8'h00, 8'h00, 8'h08, 1));
        vecs.push_back(row(0, 1, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0));
        runTable();

        // Bounce on bit 0 for 10 cycles, then a stable high
        for (int i = 0; i < 10; i++) begin
            runRow(row(0, 1, (i % 2 == 0) ? 8'h01 : 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        end
        vecs.push_back(row(0, 1, 8'h01, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 1, 8'h01, 8'h01, 8'h00, 1));
        vecs.push_back(row(0, 1, 8'h01, 2, 8'h01, 8'h00, 8'h00, 0));
        // Enable dropped after two counts, held low 10 cycles, restarts from zero
        vecs.push_back(row(0, 1, 8'h03, 4, 8'h01, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 0, 8'h03, 10, 8'h01, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h03, 3, 8'h01, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h03, 1, 8'h03, 8'h02, 8'h00, 1));
        vecs.push_back(row(0, 1, 8'h03, 2, 8'h03, 8'h00, 8'h00, 0));
        // Enable low exactly on the edge that would flip bit 1
        vecs.push_back(row(0, 1, 8'h01, 5, 8'h03, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 0, 8'h01, 1, 8'h03, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 3, 8'h03, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 1, 8'h01, 8'h00, 8'h02, 1));
        vecs.push_back(row(0, 1, 8'h01, 2, 8'h01, 8'h00, 8'h00, 0));
        // Reset while bit 0 is pending a rise: full latency again after release
        vecs.push_back(row(0, 1, 8'h00, 5, 8'h01, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1));
        vecs.push_back(row(0, 1, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 4, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(1, 1, 8'h01, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(row(0, 1, 8'h01, 1, 8'h01, 8'h01, 8'h00, 1));
        vecs.push_back(row(0, 1, 8'h01, 2, 8'h01, 8'h00, 8'h00, 0));
        runTable();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
